// File: rtl/elastic_async_operator.sv
// rtl/elastic_async_operator.sv - elastic join / compute / eager-fork dataflow operator
//
// Each operand port owns a DEPTH-entry FIFO filled through a level req_l /
// one-cycle ack_l handshake. When every operand FIFO holds data and the
// shared result FIFO has room, one operand is popped from each port, the
// result is computed and pushed. OUTPUT_SIZE consumers read the result FIFO
// through private read pointers; an entry is freed once all of them passed it.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   req_l / ack_l   per-operand request (level) / acknowledge (one cycle)
//   din             operand i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   req_r / ack_r   per-consumer request (level) / acknowledge (one cycle)
//   dout            result for consumer j, valid while ack_r[j] is high
//   full_err        sticky: an ack_l arrived while its req_l was low
// Optional (macro ELASTIC_OP_STATS_EN):
//   fire_count, in_stall_count, out_stall_count  32-bit wrapping counters
module elastic_async_operator #(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 2,
  parameter int DEPTH       = 4,
  parameter int OP          = 0,
  parameter int IMMEDIATE   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] dout,
  output logic                              full_err
`ifdef ELASTIC_OP_STATS_EN
  ,
  output logic [31:0]                       fire_count,
  output logic [31:0]                       in_stall_count,
  output logic [31:0]                       out_stall_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra wrap bit so equal indices can mean either empty or full.
  localparam int PW = AW + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [PW-1:0]         ptr_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} port_state_t;

  localparam ptr_t  DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t  ONE_P   = ptr_t'(1);
  localparam data_t IMM     = data_t'(IMMEDIATE);

  port_state_t st_q      [INPUT_SIZE];
  port_state_t st_d      [INPUT_SIZE];
  data_t       in_mem_q  [INPUT_SIZE][DEPTH];
  data_t       in_mem_d  [INPUT_SIZE][DEPTH];
  ptr_t        in_wr_q   [INPUT_SIZE];
  ptr_t        in_wr_d   [INPUT_SIZE];
  ptr_t        in_rd_q   [INPUT_SIZE];
  ptr_t        in_rd_d   [INPUT_SIZE];
  data_t       res_mem_q [DEPTH];
  data_t       res_mem_d [DEPTH];
  ptr_t        res_wr_q;
  ptr_t        res_wr_d;
  ptr_t        res_rd_q  [OUTPUT_SIZE];
  ptr_t        res_rd_d  [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0] ack_r_q;
  logic [OUTPUT_SIZE-1:0] ack_r_d;
  data_t       dout_q    [OUTPUT_SIZE];
  data_t       dout_d    [OUTPUT_SIZE];
  logic        full_err_q;
  logic        full_err_d;

`ifdef ELASTIC_OP_STATS_EN
  logic [31:0] fire_count_q, fire_count_d;
  logic [31:0] in_stall_count_q, in_stall_count_d;
  logic [31:0] out_stall_count_q, out_stall_count_d;
`endif

  logic  all_nonempty;
  logic  res_full;
  logic  fire;
  ptr_t  res_occ;
  data_t opnd [INPUT_SIZE];
  data_t result;

  // Join status and result-FIFO occupancy, which is set by the slowest consumer.
  always_comb begin : status
    all_nonempty = 1'b1;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (in_wr_q[i] == in_rd_q[i]) all_nonempty = 1'b0;
      opnd[i] = in_mem_q[i][in_rd_q[i][AW-1:0]];
    end
    res_occ = '0;
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      if ((res_wr_q - res_rd_q[j]) > res_occ) res_occ = res_wr_q - res_rd_q[j];
    end
    res_full = (res_occ == DEPTH_P);
    fire     = all_nonempty && !res_full;
  end

  // Datapath; every result is naturally truncated to DATA_WIDTH.
  always_comb begin : compute
    result = opnd[0];
    case (OP)
      1: for (int k = 1; k < INPUT_SIZE; k++) result = result + opnd[k];
      2: for (int k = 1; k < INPUT_SIZE; k++) result = result - opnd[k];
      3: for (int k = 1; k < INPUT_SIZE; k++) result = result * opnd[k];
      4: result = opnd[0] + IMM;
      5: result = opnd[0] - IMM;
      6: result = opnd[0] * IMM;
      default: result = opnd[0];
    endcase
  end

  always_comb begin : next_state
    st_d       = st_q;
    in_mem_d   = in_mem_q;
    in_wr_d    = in_wr_q;
    in_rd_d    = in_rd_q;
    res_mem_d  = res_mem_q;
    res_wr_d   = res_wr_q;
    res_rd_d   = res_rd_q;
    ack_r_d    = '0;
    dout_d     = dout_q;
    full_err_d = full_err_q;

    for (int i = 0; i < INPUT_SIZE; i++) begin
      case (st_q[i])
        ST_IDLE: begin
          // An ack with no request outstanding is dropped, only flagged.
          if (ack_l[i]) full_err_d = 1'b1;
          if ((in_wr_q[i] - in_rd_q[i]) < DEPTH_P) st_d[i] = ST_REQ;
        end
        ST_REQ: begin
          if (ack_l[i]) begin
            st_d[i] = ST_IDLE;
            in_mem_d[i][in_wr_q[i][AW-1:0]] = din[i*DATA_WIDTH +: DATA_WIDTH];
            in_wr_d[i] = in_wr_q[i] + ONE_P;
          end
        end
        default: st_d[i] = ST_IDLE;
      endcase
      if (fire) in_rd_d[i] = in_rd_q[i] + ONE_P;
    end

    if (fire) begin
      res_mem_d[res_wr_q[AW-1:0]] = result;
      res_wr_d = res_wr_q + ONE_P;
    end

    // A consumer is served at most every other cycle: the ack it is
    // currently seeing blocks the next read.
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      if (req_r[j] && !ack_r_q[j] && (res_rd_q[j] != res_wr_q)) begin
        ack_r_d[j]  = 1'b1;
        dout_d[j]   = res_mem_q[res_rd_q[j][AW-1:0]];
        res_rd_d[j] = res_rd_q[j] + ONE_P;
      end
    end

`ifdef ELASTIC_OP_STATS_EN
    fire_count_d      = fire_count_q;
    in_stall_count_d  = in_stall_count_q;
    out_stall_count_d = out_stall_count_q;
    if (fire) fire_count_d = fire_count_q + 32'd1;
    if (!all_nonempty && !res_full) in_stall_count_d = in_stall_count_q + 32'd1;
    if (all_nonempty && res_full) out_stall_count_d = out_stall_count_q + 32'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= '{default: ST_IDLE};
      in_wr_q    <= '{default: '0};
      in_rd_q    <= '{default: '0};
      res_wr_q   <= '0;
      res_rd_q   <= '{default: '0};
      ack_r_q    <= '0;
      dout_q     <= '{default: '0};
      full_err_q <= 1'b0;
`ifdef ELASTIC_OP_STATS_EN
      fire_count_q      <= '0;
      in_stall_count_q  <= '0;
      out_stall_count_q <= '0;
`endif
    end else begin
      st_q       <= st_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      ack_r_q    <= ack_r_d;
      dout_q     <= dout_d;
      full_err_q <= full_err_d;
`ifdef ELASTIC_OP_STATS_EN
      fire_count_q      <= fire_count_d;
      in_stall_count_q  <= in_stall_count_d;
      out_stall_count_q <= out_stall_count_d;
`endif
    end
  end

  // Storage needs no reset: clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    in_mem_q  <= in_mem_d;
    res_mem_q <= res_mem_d;
  end

  always_comb begin : outputs
    for (int i = 0; i < INPUT_SIZE; i++) req_l[i] = (st_q[i] == ST_REQ);
    for (int j = 0; j < OUTPUT_SIZE; j++) dout[j*DATA_WIDTH +: DATA_WIDTH] = dout_q[j];
  end

  assign ack_r    = ack_r_q;
  assign full_err = full_err_q;
`ifdef ELASTIC_OP_STATS_EN
  assign fire_count      = fire_count_q;
  assign in_stall_count  = in_stall_count_q;
  assign out_stall_count = out_stall_count_q;
`endif

endmodule

// File: tb/tb_elastic_async_operator.sv
// tb/tb_elastic_async_operator.sv - randomized scoreboard bench for elastic_async_operator
module tb_elastic_async_operator;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: 2 operands, add, 2 consumers, DATA_WIDTH 8
  logic [1:0]  req_l_a, ack_l_a, req_r_a, ack_r_a;
  logic [15:0] din_a, dout_a;
  logic        full_err_a;
  // Instance B: 1 operand, addi #2, 1 consumer, DATA_WIDTH 8
  logic [0:0]  req_l_b, ack_l_b, req_r_b, ack_r_b;
  logic [7:0]  din_b, dout_b;
  logic        full_err_b;
`ifdef ELASTIC_OP_STATS_EN
  logic [31:0] fire_count_a, in_stall_count_a, out_stall_count_a;
  logic [31:0] fire_count_b, in_stall_count_b, out_stall_count_b;
`endif

  elastic_async_operator #(.DATA_WIDTH(8), .INPUT_SIZE(2), .OUTPUT_SIZE(2),
                           .DEPTH(4), .OP(1), .IMMEDIATE(0)) dut_a (
    .clk(clk), .rst(rst), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a),
    .req_r(req_r_a), .ack_r(ack_r_a), .dout(dout_a), .full_err(full_err_a)
`ifdef ELASTIC_OP_STATS_EN
    , .fire_count(fire_count_a), .in_stall_count(in_stall_count_a),
    .out_stall_count(out_stall_count_a)
`endif
  );

  elastic_async_operator #(.DATA_WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1),
                           .DEPTH(4), .OP(4), .IMMEDIATE(2)) dut_b (
    .clk(clk), .rst(rst), .req_l(req_l_b), .ack_l(ack_l_b), .din(din_b),
    .req_r(req_r_b), .ack_r(ack_r_b), .dout(dout_b), .full_err(full_err_b)
`ifdef ELASTIC_OP_STATS_EN
    , .fire_count(fire_count_b), .in_stall_count(in_stall_count_b),
    .out_stall_count(out_stall_count_b)
`endif
  );

  // Reference model: accepted operands, and the result stream every consumer must see.
  logic [7:0] in0_q[$];
  logic [7:0] in1_q[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         got_a[2];
  int         got_b;
  logic [1:0] prev_ack_a;
  logic       prev_ack_b;
  logic [7:0] first_dout_b;
  bit         force_ff_b;
  int         p_ack, p_req;
  bit         hold_c1;
  int         checks, failures;
  int         start0, start1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    in0_q.delete(); in1_q.delete(); exp_a.delete(); exp_b.delete();
    got_a[0] = 0; got_a[1] = 0; got_b = 0;
    prev_ack_a = '0; prev_ack_b = 1'b0; first_dout_b = 8'h00;
  endtask

  task automatic observe();
    for (int j = 0; j < 2; j++) begin
      if (ack_r_a[j]) begin
        chk("a_ack_pulse", prev_ack_a[j], 0);
        if (got_a[j] < exp_a.size()) chk("a_dout", dout_a[j*8 +: 8], exp_a[got_a[j]]);
        else chk("a_unexpected_ack", ack_r_a[j], 0);
        got_a[j]++;
      end
    end
    prev_ack_a = ack_r_a;
    if (ack_r_b[0]) begin
      chk("b_ack_pulse", prev_ack_b, 0);
      if (got_b == 0) first_dout_b = dout_b;
      if (got_b < exp_b.size()) chk("b_dout", dout_b, exp_b[got_b]);
      else chk("b_unexpected_ack", ack_r_b[0], 0);
      got_b++;
    end
    prev_ack_b = ack_r_b[0];
  endtask

  task automatic drive();
    logic [7:0] v;
    for (int i = 0; i < 2; i++) begin
      if (req_l_a[i] && ($urandom_range(99) < p_ack)) begin
        v = 8'($urandom);
        ack_l_a[i] = 1'b1;
        din_a[i*8 +: 8] = v;
        if (i == 0) in0_q.push_back(v);
        else in1_q.push_back(v);
      end else begin
        ack_l_a[i] = 1'b0;
      end
    end
    while (in0_q.size() > 0 && in1_q.size() > 0)
      exp_a.push_back(8'(in0_q.pop_front() + in1_q.pop_front()));
    req_r_a[0] = ($urandom_range(99) < p_req);
    req_r_a[1] = hold_c1 ? 1'b0 : ($urandom_range(99) < p_req);

    if (req_l_b[0] && (force_ff_b || ($urandom_range(99) < p_ack))) begin
      v = force_ff_b ? 8'hFF : 8'($urandom);
      force_ff_b = 1'b0;
      ack_l_b[0] = 1'b1;
      din_b = v;
      exp_b.push_back(8'(v + 8'd2));
    end else begin
      ack_l_b[0] = 1'b0;
    end
    req_r_b[0] = ($urandom_range(99) < p_req);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      observe();
      drive();
    end
  endtask

  task automatic drain_and_check();
    p_ack = 0; p_req = 100; hold_c1 = 1'b0;
    cycles(40);
    chk("a_count_c0", got_a[0], exp_a.size());
    chk("a_count_c1", got_a[1], exp_a.size());
    chk("b_count", got_b, exp_b.size());
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    ack_l_a = '0; din_a = '0; req_r_a = '0;
    ack_l_b = '0; din_b = '0; req_r_b = '0;
    force_ff_b = 1'b0; p_ack = 0; p_req = 0; hold_c1 = 1'b0;
    clear_model();

    repeat (3) @(negedge clk);
    chk("rst_req_l_a", req_l_a, 0);
    chk("rst_ack_r_a", ack_r_a, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_full_err_a", full_err_a, 0);
    chk("rst_req_l_b", req_l_b, 0);
    chk("rst_dout_b", dout_b, 0);
    rst = 1'b1;
    chk("release_req_l", req_l_a, 0);

    // Latency: ack_l pair at edge t -> ack_r at edge t+2.
    @(negedge clk);
    observe();
    chk("first_req_l", req_l_a, 2'b11);
    p_ack = 100; p_req = 100;
    drive();
    p_ack = 0;
    cycles(1); chk("lat_edge_t", ack_r_a, 2'b00);
    cycles(1); chk("lat_edge_t1", ack_r_a, 2'b00);
    cycles(1); chk("lat_edge_t2", ack_r_a, 2'b11);

    p_ack = 60; p_req = 50;
    cycles(400);
    drain_and_check();

    // Asynchronous reset between clock edges, mid-stream.
    p_ack = 70; p_req = 60;
    cycles(50);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req_l_a", req_l_a, 0);
    chk("mid_rst_ack_r_a", ack_r_a, 0);
    chk("mid_rst_req_l_b", req_l_b, 0);
    chk("mid_rst_ack_r_b", ack_r_b, 0);
    ack_l_a = '0; ack_l_b = '0; req_r_a = '0; req_r_b = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("release2_req_l", req_l_a, 0);

    // Stray ack while req_l[0] is low: ignored, flags full_err.
    ack_l_a = 2'b01; din_a = 16'h00AA;
    force_ff_b = 1'b1; p_ack = 60; p_req = 60;
    @(negedge clk);
    observe();
    chk("full_err_set", full_err_a, 1);
    chk("req_after_release", req_l_a, 2'b11);
    drive();
    for (int k = 0; k < 40 && got_b == 0; k++) cycles(1);
    chk("b_wrap_ff_plus_2", first_dout_b, 8'h01);
    cycles(200);
    drain_and_check();

    // Consumer 1 stalls for 40 cycles; consumer 0 gets one FIFO's worth.
    start0 = got_a[0]; start1 = got_a[1];
    p_ack = 100; p_req = 100; hold_c1 = 1'b1;
    cycles(40);
    chk("stall_c0_results", got_a[0] - start0, 4);
    chk("stall_c1_results", got_a[1] - start1, 0);
    chk("stall_req_l", req_l_a, 0);
`ifdef ELASTIC_OP_STATS_EN
    chk("out_stall_nonzero", out_stall_count_a != 0, 1);
`endif
    hold_c1 = 1'b0; p_ack = 60; p_req = 60;
    cycles(200);
    drain_and_check();
`ifdef ELASTIC_OP_STATS_EN
    chk("fire_count", fire_count_a, got_a[0]);
`endif
    chk("full_err_sticky", full_err_a, 1);
    chk("b_full_err_clear", full_err_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elastic_async_operator.md
Name: elastic_async_operator

Overview:
- Parametrised successor to the single-slot handshake operator used in the arf dataflow graphs.
- Join side: each of INPUT_SIZE operand ports has its own DEPTH-entry FIFO, so upstream producers are decoupled.
- Fork side: a shared DEPTH-entry result FIFO, read independently by OUTPUT_SIZE consumers (eager fork). A slow consumer does not stall fast ones until the result FIFO fills.
- Drops into arf in place of any operator node (in/out/reg/arith).

Parameters:
- DATA_WIDTH, 32, operand/result width
- INPUT_SIZE, 2, number of operand ports (1..3)
- OUTPUT_SIZE, 2, number of fork consumers (1..8)
- DEPTH, 4, entries per input FIFO and in the result FIFO (power of 2, >=2)
- OP, 0, operation: 0 pass, 1 add, 2 sub, 3 mul, 4 addi, 5 subi, 6 muli
- IMMEDIATE, 0, constant for OP 4..6

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_l  out  INPUT_SIZE  per-input request to upstream (level)
- ack_l  in  INPUT_SIZE  per-input one-cycle ack; din slice is valid in that cycle
- din  in  INPUT_SIZE*DATA_WIDTH  operand i at bits [DW*(i+1)-1:DW*i]
- req_r  in  OUTPUT_SIZE  per-consumer request (level)
- ack_r  out  OUTPUT_SIZE  per-consumer one-cycle ack
- dout  out  OUTPUT_SIZE*DATA_WIDTH  result for consumer j, valid while ack_r[j]=1
- full_err  out  1  sticky; set when an ack_l arrives with req_l low

Behaviour:
- Reset (rst=0, asynchronous, effective immediately)
  - req_l=0, ack_r=0, dout=0, full_err=0.
  - All FIFO pointers and counts are cleared.
  - Reset mid-transfer discards all buffered data.
  - The first req_l rises on the first clk edge after rst deasserts.
- Input port i, per-port states:
  - IDLE -> REQ when occ_i < DEPTH; req_l[i] goes to 1 on that edge.
  - REQ -> IDLE on a sampled ack_l[i]=1; din_i is written to FIFO i and req_l[i] goes to 0 on that edge.
  - At most one outstanding request per port; peak rate is one operand per 2 cycles per port.
  - ack_l[i] with req_l[i]=0 is ignored (no write) and sets full_err.
- Fire condition: all input FIFOs non-empty and result occupancy < DEPTH.
  - On fire: pop one entry from every input FIFO, compute the result, push it into the result FIFO, all in the same edge.
  - Pop and write on the same FIFO in the same cycle are both honoured; occupancy stays unchanged.
- Arithmetic (x_k = input FIFO k head)
  - add: x0+x1(+x2).
  - sub: x0-x1(-x2).
  - mul: product.
  - Immediate ops use x0 only.
  - pass uses x0.
  - All results are truncated modulo 2^DATA_WIDTH; no saturation.
- Output fork, one read pointer per consumer j:
  - If req_r[j]=1, ack_r[j]=0 and consumer j has an unread entry: on the next edge ack_r[j]=1 and dout_j = the entry at read pointer j; the pointer then advances.
  - ack_r[j] always returns to 0 the following cycle.
  - Peak rate is one result per 2 cycles per consumer.
- Result entry freeing
  - An entry is freed only when every consumer's pointer has passed it; occupancy = write pointer minus the slowest read pointer.
  - Full: no fire.
  - Empty for consumer j: no ack_r[j].
  - Pointers wrap modulo DEPTH with an extra wrap bit to disambiguate full from empty.
- Latency: ack_l sampled at edge t → fire at edge t+1 → earliest ack_r at edge t+2.
- Simultaneous events:
  - Fire and consumer reads on the same edge are both honoured.
  - The freed slot is usable for a fire on the next edge.

Optional Feature:
- ELASTIC_OP_STATS_EN defined: adds three 32-bit outputs, all reset to 0 and wrapping modulo 2^32.
  - fire_count: increments once per fire.
  - in_stall_count: increments per cycle in which the fire condition fails only because some input FIFO is empty.
  - out_stall_count: increments per cycle in which all inputs are ready but the result FIFO is full.
- ELASTIC_OP_STATS_EN undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- INPUT_SIZE=2, OP=add, OUTPUT_SIZE=1, always-ready producers giving 0,1,2… on both ports → consumer receives 0,2,4,…; first ack_r exactly 2 edges after the first ack_l pair.
- OP=addi, IMMEDIATE=2, DATA_WIDTH=8, input 8'hFF → dout 8'h01 (wrap-around).
- OUTPUT_SIZE=2, consumer 1 holds req_r=0 for 40 cycles, DEPTH=4 → consumer 0 receives 4 results, then req_l stalls; after consumer 1 resumes it receives those same 4 results in order, then flow resumes with no loss or duplication.
- Inject ack_l[0] while req_l[0]=0 → FIFO unchanged, full_err=1 and remains set until reset.
- Assert rst=0 mid-stream between clock edges → req_l and ack_r go to 0 immediately; after release the first result equals f(first post-reset operands).
- With ELASTIC_OP_STATS_EN defined and stimulus as in scenario 3 → out_stall_count>0 and fire_count equals the number of results received by consumer 0.
